// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - access size encodings, controller FSM states and byte-lane mask helper
package riscv_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Halves ignore offset[0] and words ignore the offset, which forces natural alignment.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << offset;
      SZ_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - selects the addressed byte/half of a memory word and sign/zero-extends it
module riscv_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {offset, 3'b000});
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// rtl/riscv_dmem_ctrl.sv - single-port data memory controller with fixed wait states
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of forcing alignment.
module riscv_dmem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        q_we, q_unsigned;
  logic [1:0]  q_size;
  logic [31:0] q_addr, q_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, last_cycle, do_write, misalign, cur_err;
  logic          cur_we, cur_unsigned;
  logic [1:0]    cur_size;
  logic [31:0]   cur_addr, cur_wdata, lane_data, ld_data;
  logic [AW-1:0] idx;
  logic [3:0]    be;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait states the write lands in the accept cycle, so the live request is used there.
  assign cur_we       = (state == ST_IDLE) ? req_we       : q_we;
  assign cur_size     = (state == ST_IDLE) ? req_size     : q_size;
  assign cur_unsigned = (state == ST_IDLE) ? req_unsigned : q_unsigned;
  assign cur_addr     = (state == ST_IDLE) ? req_addr     : q_addr;
  assign cur_wdata    = (state == ST_IDLE) ? req_wdata    : q_wdata;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                    ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign cur_err = (cur_size == 2'b11) ||
                   ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                   misalign;
  assign idx = cur_addr[AW+1:2];
  assign be  = lane_mask(cur_size, cur_addr[1:0]);

  always_comb begin
    case (cur_size)
      SZ_BYTE: lane_data = {4{cur_wdata[7:0]}};
      SZ_HALF: lane_data = {2{cur_wdata[15:0]}};
      default: lane_data = cur_wdata;
    endcase
  end

  assign last_cycle = ((state == ST_WAIT) && (cnt == 4'd0)) || (accept && (WAIT_STATES == 0));
  assign do_write   = last_cycle && cur_we && !cur_err && !rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            q_we       <= req_we;
            q_size     <= req_size;
            q_unsigned <= req_unsigned;
            q_addr     <= req_addr;
            q_wdata    <= req_wdata;
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  riscv_load_align u_load_align (
    .word        (mem[idx]),
    .size        (cur_size),
    .offset      (cur_addr[1:0]),
    .is_unsigned (cur_unsigned),
    .data        (ld_data)
  );

  assign rsp_valid = (state == ST_RESP) && !rst;
  assign rsp_err   = rsp_valid && cur_err;
  assign rsp_rdata = (rsp_valid && !cur_we && !cur_err) ? ld_data : 32'd0;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb/tb_riscv_dmem_ctrl.sv - self-checking bench for riscv_dmem_ctrl at 0, 1 and 3 wait states
// Expectations honour DMEM_MISALIGN_CHECK_EN when it is defined.
module tb_riscv_dmem_ctrl;
  import riscv_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, vld, rdy, rv, re;
  logic [2:0][31:0] rd;
  logic             req_we, req_unsigned;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;

  int checks = 0;
  int errors = 0;
  int ws_of [3] = '{0, 1, 3};
  logic [7:0] mb [3][1024];

  riscv_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));
  riscv_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));
  riscv_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed little-endian memory; accesses are naturally aligned unless flagged.
  task automatic model(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rdv);
    int n, base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (a >= 32'd1024);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) err = 1'b1;
`endif
    rdv = 32'd0;
    if (err) return;
    base = (int'(a) / n) * n;
    if (we) begin
      for (int k = 0; k < n; k++) mb[i][base + k] = wd[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mb[i][base + k];
      if (!uns && n < 4 && v[8*n - 1]) v = v - (32'd1 << (8*n));
      rdv = v;
    end
  endtask

  task automatic do_req(input int i, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err);
    logic        exp_err, busy_bad;
    logic [31:0] exp_rd;
    int          lat;
    bit          seen;
    model(i, we, sz, uns, a, wd, exp_err, exp_rd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    vld[i] = 1'b1;
    check("ready_idle", 32'(rdy[i]), 32'd1);
    @(posedge clk); #1;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; seen = 0; busy_bad = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rv[i]) seen = 1;
      else if (rdy[i] || re[i] || rd[i] != 32'd0) busy_bad = 1'b1;
    end
    vld[i] = 1'b0;
    got_rd = rd[i];
    got_err = re[i];
    check("busy_quiet", 32'(busy_bad), 32'd0);
    check("rsp_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(ws_of[i] + 1));
    check("rdata", rd[i], exp_rd);
    check("err", 32'(re[i]), 32'(exp_err));
    @(negedge clk);
    check("rsp_pulse", 32'(rv[i]), 32'd0);
    check("ready_back", 32'(rdy[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] g, a;
    logic        e, e_st;
    bit          seen;

    rst = 3'b111; vld = 3'b000;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    @(negedge clk);
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_valid", 32'(rv), 32'd0);
    check("rst_err", 32'(re), 32'd0);
    rst = 3'b000;
    @(negedge clk);
    check("post_rst_ready", 32'(rdy), 32'd7);
    check("post_rst_valid", 32'(rv), 32'd0);
    for (int i = 0; i < 3; i++) check("post_rst_rdata", rd[i], 32'd0);

    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 256; w++) do_req(i, 1'b1, SZ_WORD, 1'b0, 32'(w * 4), $urandom, g, e);

    rst = 3'b111;
    @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      repeat (6) do_req(i, 1'b0, SZ_WORD, 1'b0, 32'($urandom_range(0, 255) * 4), 32'd0, g, e);

    do_req(1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, g, e);
    check("d_store_err", 32'(e), 32'd0);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, g, e);
    check("d_load_word", g, 32'hDEADBEEF);
    do_req(1, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, g, e);
    check("d_lb_signed", g, 32'hFFFFFFDE);
    do_req(1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, g, e);
    check("d_lb_unsigned", g, 32'h000000DE);
    do_req(1, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00001234, g, e);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, g, e);
    check("d_half_merge", g, 32'h1234BEEF);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'd0, g, e);
    check("d_oob_load_err", 32'(e), 32'd1);
    check("d_oob_load_rd", g, 32'd0);
    do_req(1, 1'b1, SZ_WORD, 1'b0, 32'h400, 32'hFFFFFFFF, g, e);
    check("d_oob_store_err", 32'(e), 32'd1);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'd0, g, e);
    do_req(1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, g, e);
    check("d_size11_err", 32'(e), 32'd1);
    do_req(1, 1'b1, SZ_WORD, 1'b0, 32'h11, 32'hCAFEF00D, g, e_st);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, g, e);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("d_misalign_err", 32'(e_st), 32'd1);
    check("d_misalign_word", g, 32'h1234BEEF);
`else
    check("d_misalign_err", 32'(e_st), 32'd0);
    check("d_misalign_word", g, 32'hCAFEF00D);
`endif

    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 9))
          0:       a = 32'h400 + 32'($urandom_range(0, 255));
          1:       a = $urandom;
          default: a = 32'($urandom_range(0, 1023));
        endcase
        do_req(i, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, g, e);
      end
    end

    req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
    vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    rst[2] = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(rdy[2]), 32'd0);
    check("midrst_valid", 32'(rv[2]), 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(rdy[2]), 32'd1);
    seen = 0;
    repeat (8) begin
      if (rv[2]) seen = 1;
      @(negedge clk);
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    do_req(2, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0, g, e);
    check("midrst_unchanged", 32'(g != 32'h55AA55AA || {mb[2][35], mb[2][34], mb[2][33], mb[2][32]} == 32'h55AA55AA), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
